// File: rtl/sfm_fma_arbiter.sv
// Arbiter that shares one fixed-latency, non-stallable FMA between N_REQ requesters.
// In-flight ops are tagged with their issuer so each result can be routed back to it.
module sfm_fma_arbiter #(
  parameter int unsigned N_REQ   = 2,
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned FMA_LAT = 3,
  parameter int unsigned OP_W    = 2
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    clear_i,
  input  logic [N_REQ-1:0]        req_valid_i,
  output logic [N_REQ-1:0]        req_ready_o,
  input  logic [N_REQ-1:0]        req_lock_i,
  input  logic [N_REQ*OP_W-1:0]   req_op_i,
  input  logic [N_REQ*DATA_W-1:0] req_a_i,
  input  logic [N_REQ*DATA_W-1:0] req_b_i,
  input  logic [N_REQ*DATA_W-1:0] req_c_i,
  output logic                    fma_valid_o,
  output logic [OP_W-1:0]         fma_op_o,
  output logic [DATA_W-1:0]       fma_a_o,
  output logic [DATA_W-1:0]       fma_b_o,
  output logic [DATA_W-1:0]       fma_c_o,
  input  logic                    fma_res_valid_i,
  input  logic [DATA_W-1:0]       fma_res_i,
  output logic [N_REQ-1:0]        res_valid_o,
  output logic [DATA_W-1:0]       res_o,
  output logic                    busy_o,
  output logic                    err_o
);

  localparam int unsigned IDW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int unsigned CW  = $clog2(FMA_LAT + 1);

  typedef enum logic {ST_UNLOCKED, ST_LOCKED} state_e;

  state_e                        state_q, state_d;
  logic [IDW-1:0]                owner_q, owner_d;
  logic [IDW-1:0]                rr_q, rr_d;
  logic [FMA_LAT-1:0]            vld_q, vld_d;
  logic [FMA_LAT-1:0][IDW-1:0]   id_q, id_d;
  logic [CW-1:0]                 ign_q, ign_d;
  logic                          err_q, err_d;

  logic [IDW-1:0] grant;
  logic           found;
  logic           issue;
  int unsigned    idx;
  logic           tail_vld;
  logic [IDW-1:0] tail_id;
  logic           ignore;
  logic           res_ok;
  logic           mismatch;

  // Grant: lock owner only while locked, otherwise round-robin from rr_q
  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = 0;
    if (state_q == ST_LOCKED) begin
      grant = owner_q;
      found = req_valid_i[owner_q];
    end else begin
      for (int unsigned k = 0; k < N_REQ; k++) begin
        idx = 32'(rr_q) + k;
        if (idx >= N_REQ) idx = idx - N_REQ;
        if (!found && req_valid_i[IDW'(idx)]) begin
          found = 1'b1;
          grant = IDW'(idx);
        end
      end
    end
  end

  // Reset gates issue so every output reads 0 while rst_i is high
  assign issue       = found && !clear_i && !rst_i;
  assign fma_valid_o = issue;
  assign req_ready_o = issue ? (N_REQ'(1) << grant) : '0;

  always_comb begin
    fma_op_o = '0;
    fma_a_o  = '0;
    fma_b_o  = '0;
    fma_c_o  = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (issue && (grant == IDW'(i))) begin
        fma_op_o = req_op_i[i*OP_W +: OP_W];
        fma_a_o  = req_a_i[i*DATA_W +: DATA_W];
        fma_b_o  = req_b_i[i*DATA_W +: DATA_W];
        fma_c_o  = req_c_i[i*DATA_W +: DATA_W];
      end
    end
  end

  assign tail_vld = vld_q[FMA_LAT-1];
  assign tail_id  = id_q[FMA_LAT-1];
  // After clear/reset the FMA may still emit results for flushed ops; mask them
  assign ignore   = clear_i || rst_i || (ign_q != '0);
  assign res_ok   = !ignore && fma_res_valid_i && tail_vld;
  assign mismatch = !ignore && (fma_res_valid_i != tail_vld);

  assign res_valid_o = res_ok ? (N_REQ'(1) << tail_id) : '0;
  assign res_o       = res_ok ? fma_res_i : '0;
  assign busy_o      = (|vld_q) || (state_q == ST_LOCKED);
  assign err_o       = err_q;

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    rr_d    = rr_q;
    case (state_q)
      ST_UNLOCKED: begin
        if (issue) begin
          rr_d = (32'(grant) == N_REQ - 1) ? '0 : grant + IDW'(1);
          if (req_lock_i[grant]) begin
            state_d = ST_LOCKED;
            owner_d = grant;
          end
        end
      end
      ST_LOCKED: begin
        if (!req_lock_i[owner_q]) state_d = ST_UNLOCKED;
      end
      default: state_d = ST_UNLOCKED;
    endcase
    if (clear_i) begin
      state_d = ST_UNLOCKED;
      owner_d = '0;
      rr_d    = '0;
    end
  end

  always_comb begin
    vld_d    = '0;
    id_d     = id_q;
    vld_d[0] = issue;
    id_d[0]  = grant;
    for (int unsigned i = 1; i < FMA_LAT; i++) begin
      vld_d[i] = vld_q[i-1];
      id_d[i]  = id_q[i-1];
    end
    if (clear_i) vld_d = '0;

    ign_d = ign_q;
    if (clear_i)           ign_d = CW'(FMA_LAT);
    else if (ign_q != '0)  ign_d = ign_q - CW'(1);

    err_d = clear_i ? 1'b0 : (err_q || mismatch);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_UNLOCKED;
      owner_q <= '0;
      rr_q    <= '0;
      vld_q   <= '0;
      id_q    <= '0;
      ign_q   <= CW'(FMA_LAT);
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      rr_q    <= rr_d;
      vld_q   <= vld_d;
      id_q    <= id_d;
      ign_q   <= ign_d;
      err_q   <= err_d;
    end
  end

endmodule
